stop_watch_lap: RTL and testbench

- Stopwatch core with a configurable tick prescaler, cascaded centisecond/second/minute counters, a display freeze/update register and a lap (split) memory with recall.
- Sits after the key debounce/enable stage. `k0`/`k1`/`k2` are single-cycle key enables.
- Outputs drive the display formatter directly.

---
 rtl/stop_watch_lap.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_stop_watch_lap.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stop_watch_lap.sv
// -----------------------------------------------------------------------------
// stop_watch_lap
//
// Stopwatch core for the display path. It takes single-cycle key enables from
// the debounce stage and produces the value shown on the display, plus status.
//
//   - A prescaler divides clk down to a centisecond tick while running.
//   - Cascaded centi (0..99) / sec (0..59) / min (0..MIN_MAX-1) live counters.
//   - A display register that follows the live count, freezes on a lap
//     capture, or shows a recalled lap.
//   - A lap memory of LAP_DEPTH entries with a recall/browse mode.
//
// Optional build macro: STOP_WATCH_LAP_DELTA_EN
//   When defined, a second counter chain measures the time since the previous
//   capture (or since start). Laps and the SPLIT display then hold that delta
//   instead of cumulative time.
//
// Parameters
//   CLK_DIV   clk cycles per centisecond tick (>= 2)
//   MIN_MAX   minute counter modulus
//   LAP_DEPTH number of stored laps (>= 1)
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   k0              start / pause key enable
//   k1              lap / reset / exit key enable
//   k2              recall / next-lap key enable
//   running         time base advancing (RUN or SPLIT)
//   frozen          display not following the live count (SPLIT or RECALL)
//   disp_centi/sec/min  displayed time
//   lap_cnt         number of stored laps
//   lap_idx         lap shown while recalling
//   lap_full        lap memory full
//   ovf             sticky: minute counter has wrapped
// -----------------------------------------------------------------------------
module stop_watch_lap #(
  parameter int CLK_DIV   = 10,
  parameter int MIN_MAX   = 60,
  parameter int LAP_DEPTH = 4,
  localparam int MW = $clog2(MIN_MAX),
  localparam int LW = $clog2(LAP_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          k0,
  input  logic          k1,
  input  logic          k2,
  output logic          running,
  output logic          frozen,
  output logic [6:0]    disp_centi,
  output logic [5:0]    disp_sec,
  output logic [MW-1:0] disp_min,
  output logic [LW-1:0] lap_cnt,
  output logic [LW-1:0] lap_idx,
  output logic          lap_full,
  output logic          ovf
);

  localparam int PW = $clog2(CLK_DIV);
  // Lap storage is sized to the full index range so lap_cnt/lap_idx can index
  // it directly; slots at or above LAP_DEPTH are never written or read.
  localparam int LAP_SLOTS = 1 << LW;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_PAUSE  = 3'd2,
    S_SPLIT  = 3'd3,
    S_RECALL = 3'd4
  } state_e;

  typedef struct packed {
    logic [MW-1:0] mins;
    logic [5:0]    secs;
    logic [6:0]    centi;
  } stamp_t;

  // One centisecond step through the cascaded counters.
  function automatic stamp_t time_inc(input stamp_t t);
    stamp_t r;
    r = t;
    if (t.centi == 7'd99) begin
      r.centi = 7'd0;
      if (t.secs == 6'd59) begin
        r.secs = 6'd0;
        r.mins = (t.mins == MW'(MIN_MAX - 1)) ? '0 : t.mins + MW'(1);
      end else begin
        r.secs = t.secs + 6'd1;
      end
    end else begin
      r.centi = t.centi + 7'd1;
    end
    return r;
  endfunction

  // True when the next step wraps the whole count back to zero.
  function automatic logic time_is_last(input stamp_t t);
    return (t.centi == 7'd99) && (t.secs == 6'd59) &&
           (t.mins == MW'(MIN_MAX - 1));
  endfunction

  state_e        state_q, state_d;
  state_e        ret_q, ret_d;
  logic          key0, key1, key2;
  logic          has_laps;
  logic          start, capture, clear_all, enter_recall, recall_next;
  logic          tick;
  logic [PW-1:0] presc_q, presc_d;
  stamp_t        live_q, live_d;
  stamp_t        disp_q, disp_d;
  stamp_t        cap_val;
  logic          ovf_q, ovf_d;
  logic [LW-1:0] lap_cnt_q, lap_cnt_d;
  logic [LW-1:0] lap_idx_q, lap_idx_d;
  logic          lap_full_w;
  logic          lap_we;
  stamp_t        lap_mem_q [LAP_SLOTS];

  // Key priority k0 > k1 > k2: lower keys are discarded when a higher one acts.
  assign key0 = k0;
  assign key1 = k1 & ~k0;
  assign key2 = k2 & ~k0 & ~k1;

  assign has_laps   = (lap_cnt_q != '0);
  assign lap_full_w = (lap_cnt_q == LW'(LAP_DEPTH));

  // Events decoded from the current state and the winning key.
  assign start        = (state_q == S_IDLE) && key0;
  assign capture      = ((state_q == S_RUN) || (state_q == S_SPLIT)) && key1;
  assign clear_all    = (state_q == S_PAUSE) && key1;
  assign enter_recall = ((state_q == S_IDLE) || (state_q == S_PAUSE)) &&
                        key2 && has_laps;
  assign recall_next  = (state_q == S_RECALL) && key2;
  assign lap_we       = capture && !lap_full_w;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    if (enter_recall) begin
      ret_d = state_q;
    end
    unique case (state_q)
      S_IDLE: begin
        if (key0) begin
          state_d = S_RUN;
        end else if (enter_recall) begin
          state_d = S_RECALL;
        end
      end
      S_RUN: begin
        if (key0) begin
          state_d = S_PAUSE;
        end else if (key1) begin
          state_d = S_SPLIT;
        end
      end
      S_SPLIT: begin
        if (key0) begin
          state_d = S_RUN;
        end
      end
      S_PAUSE: begin
        if (key0) begin
          state_d = S_RUN;
        end else if (key1) begin
          state_d = S_IDLE;
        end else if (enter_recall) begin
          state_d = S_RECALL;
        end
      end
      S_RECALL: begin
        if (key1) begin
          state_d = ret_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    running = (state_q == S_RUN) || (state_q == S_SPLIT);
    frozen  = (state_q == S_SPLIT) || (state_q == S_RECALL);
  end

  // ---------------------------------------------------------------------------
  // Time base: prescaler and live counters
  // ---------------------------------------------------------------------------
  assign tick = running && (presc_q == PW'(CLK_DIV - 1));

  always_comb begin
    presc_d = presc_q;
    live_d  = live_q;
    ovf_d   = ovf_q;
    if (start || clear_all) begin
      presc_d = '0;
      live_d  = '0;
    end else if (running) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        live_d = time_inc(live_q);
      end
    end
    if (clear_all) begin
      ovf_d = 1'b0;
    end else if (tick && time_is_last(live_q)) begin
      ovf_d = 1'b1;
    end
  end

`ifdef STOP_WATCH_LAP_DELTA_EN
  // Split chain: time since the previous capture. On a capture that coincides
  // with a tick it restarts at one centisecond so the tick is not lost and
  // consecutive deltas always sum to the cumulative time.
  stamp_t split_q, split_d;

  always_comb begin
    split_d = split_q;
    if (start) begin
      split_d = '0;
    end else if (capture) begin
      split_d = tick ? time_inc(stamp_t'(0)) : '0;
    end else if (tick) begin
      split_d = time_inc(split_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      split_q <= '0;
    end else begin
      split_q <= split_d;
    end
  end

  assign cap_val = split_q;
`else
  assign cap_val = live_q;
`endif

  // ---------------------------------------------------------------------------
  // Display register and lap bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    disp_d = disp_q;
    if (clear_all) begin
      disp_d = '0;
    end else if (capture) begin
      disp_d = cap_val;
    end else if ((state_q == S_RECALL) && !key1) begin
      disp_d = lap_mem_q[lap_idx_q];
    end else if ((state_q != S_SPLIT) || key0) begin
      // Live-following states, leaving SPLIT, and leaving RECALL all reload
      // the live count; only an idle SPLIT holds.
      disp_d = live_q;
    end
  end

  always_comb begin
    lap_cnt_d = lap_cnt_q;
    lap_idx_d = lap_idx_q;
    if (clear_all) begin
      lap_cnt_d = '0;
    end else if (lap_we) begin
      lap_cnt_d = lap_cnt_q + LW'(1);
    end
    if (enter_recall) begin
      lap_idx_d = '0;
    end else if (recall_next) begin
      lap_idx_d = (lap_idx_q + LW'(1) == lap_cnt_q) ? '0 : lap_idx_q + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      live_q    <= '0;
      disp_q    <= '0;
      ovf_q     <= 1'b0;
      lap_cnt_q <= '0;
      lap_idx_q <= '0;
    end else begin
      presc_q   <= presc_d;
      live_q    <= live_d;
      disp_q    <= disp_d;
      ovf_q     <= ovf_d;
      lap_cnt_q <= lap_cnt_d;
      lap_idx_q <= lap_idx_d;
    end
  end

  // Lap contents are only meaningful below lap_cnt, so they need no reset.
  always_ff @(posedge clk) begin
    if (lap_we) begin
      lap_mem_q[lap_cnt_q] <= cap_val;
    end
  end

  assign disp_centi = disp_q.centi;
  assign disp_sec   = disp_q.secs;
  assign disp_min   = disp_q.mins;
  assign lap_cnt    = lap_cnt_q;
  assign lap_idx    = lap_idx_q;
  assign lap_full   = lap_full_w;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_stop_watch_lap.sv
// Testbench for stop_watch_lap. A behavioural model keeps time as a plain
// centisecond count, laps in a queue, and the operating mode as an enum; the
// displayed fields are derived from it by division.
module tb_stop_watch_lap;
  localparam int CLK_DIV   = 3;
  localparam int MIN_MAX   = 2;
  localparam int LAP_DEPTH = 4;
  localparam int MW   = $clog2(MIN_MAX);
  localparam int LW   = $clog2(LAP_DEPTH + 1);
  localparam int WRAP = MIN_MAX * 6000;
  localparam int DW   = MW + 13;
  localparam int FW   = 4 + 2 * LW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          k0 = 1'b0, k1 = 1'b0, k2 = 1'b0;
  logic          running, frozen, lap_full, ovf;
  logic [6:0]    disp_centi;
  logic [5:0]    disp_sec;
  logic [MW-1:0] disp_min;
  logic [LW-1:0] lap_cnt, lap_idx;

  stop_watch_lap #(.CLK_DIV(CLK_DIV), .MIN_MAX(MIN_MAX), .LAP_DEPTH(LAP_DEPTH)) dut (
    .clk(clk), .rst(rst), .k0(k0), .k1(k1), .k2(k2),
    .running(running), .frozen(frozen),
    .disp_centi(disp_centi), .disp_sec(disp_sec), .disp_min(disp_min),
    .lap_cnt(lap_cnt), .lap_idx(lap_idx), .lap_full(lap_full), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_SPLIT, M_RECALL} mode_t;
  mode_t m_mode, m_ret;
  int    m_live, m_disp, m_phase, m_idx, m_split;
  bit    m_ovf;
  int    m_laps[$];

  logic [DW-1:0] dut_disp;
  logic [FW-1:0] dut_flags;
  assign dut_disp  = {disp_min, disp_sec, disp_centi};
  assign dut_flags = {running, frozen, lap_full, ovf, lap_cnt, lap_idx};

  function automatic logic [DW-1:0] cs_fields(input int cs);
    logic [MW-1:0] mn;
    logic [5:0]    sc;
    logic [6:0]    ce;
    mn = MW'(cs / 6000);
    sc = 6'((cs / 100) % 60);
    ce = 7'(cs % 100);
    return {mn, sc, ce};
  endfunction

  function automatic logic [DW-1:0] exp_disp();
    return cs_fields(m_disp);
  endfunction

  function automatic logic [FW-1:0] exp_flags();
    logic r, f, full;
    r    = (m_mode == M_RUN) || (m_mode == M_SPLIT);
    f    = (m_mode == M_SPLIT) || (m_mode == M_RECALL);
    full = (m_laps.size() == LAP_DEPTH);
    return {r, f, full, m_ovf, LW'(m_laps.size()), LW'(m_idx)};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_ret = M_IDLE;
    m_live = 0; m_disp = 0; m_phase = 0; m_idx = 0; m_split = 0; m_ovf = 0;
    m_laps.delete();
  endtask

  task automatic model_capture(input int cap, input bit tick);
    if (m_laps.size() < LAP_DEPTH) m_laps.push_back(cap);
    m_split = tick ? 1 : 0;
  endtask

  task automatic model_edge(input bit a0, input bit a1, input bit a2);
    bit e0, e1, e2, run, tick;
    int nlive, nd, cap;
    mode_t nm;
    e0 = a0; e1 = a1 && !a0; e2 = a2 && !a0 && !a1;
    run  = (m_mode == M_RUN) || (m_mode == M_SPLIT);
    tick = run && (m_phase == CLK_DIV - 1);
`ifdef STOP_WATCH_LAP_DELTA_EN
    cap = m_split;
`else
    cap = m_live;
`endif
    nm = m_mode; nd = m_live; nlive = m_live;
    if (tick) begin
      nlive = (m_live + 1) % WRAP;
      if (nlive == 0) m_ovf = 1;
      m_split = (m_split + 1) % WRAP;
    end
    if (run) m_phase = (m_phase + 1) % CLK_DIV;
    case (m_mode)
      M_IDLE: begin
        if (e0) begin
          nlive = 0; m_phase = 0; m_split = 0; nm = M_RUN;
        end else if (e2 && m_laps.size() > 0) begin
          m_idx = 0; m_ret = M_IDLE; nm = M_RECALL;
        end
      end
      M_RUN: begin
        if (e0) nm = M_PAUSE;
        else if (e1) begin model_capture(cap, tick); nd = cap; nm = M_SPLIT; end
      end
      M_SPLIT: begin
        if (e0) nm = M_RUN;
        else if (e1) begin model_capture(cap, tick); nd = cap; end
        else nd = m_disp;
      end
      M_PAUSE: begin
        if (e0) nm = M_RUN;
        else if (e1) begin
          nm = M_IDLE; nlive = 0; nd = 0; m_ovf = 0; m_laps.delete();
        end else if (e2 && m_laps.size() > 0) begin
          m_idx = 0; m_ret = M_PAUSE; nm = M_RECALL;
        end
      end
      default: begin
        if (e1) nm = m_ret;
        else begin
          nd = m_laps[m_idx];
          if (e2) m_idx = (m_idx + 1) % m_laps.size();
        end
      end
    endcase
    m_live = nlive; m_disp = nd; m_mode = nm;
  endtask

  // One clock: present keys, update the model at the edge, sample at +1.
  task automatic step(input bit a0, input bit a1, input bit a2);
    k0 = a0; k1 = a1; k2 = a2;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(a0, a1, a2);
    #1;
    k0 = 1'b0; k1 = 1'b0; k2 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_tests++;
    if (dut_disp !== '0) begin
      n_fail++; $display("FAIL reset_disp got=%h exp=0", dut_disp);
    end
    n_tests++;
    if (dut_flags !== '0) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=0", dut_flags);
    end
  endtask

  task automatic test_count();
    do_reset();
    step(1, 0, 0);
    for (int i = 1; i <= 100 * CLK_DIV; i++) begin
      step(0, 0, 0);
      n_tests++;
      if (dut_disp !== exp_disp()) begin
        n_fail++; $display("FAIL count_disp cyc=%0d got=%h exp=%h", i, dut_disp, exp_disp());
      end
    end
    n_tests++;
    if ({disp_sec, disp_centi} !== {6'd0, 7'd99}) begin
      n_fail++; $display("FAIL count_099 got=%0d.%0d exp=0.99", disp_sec, disp_centi);
    end
    for (int i = 0; i < CLK_DIV; i++) step(0, 0, 0);
    n_tests++;
    if ({running, disp_sec, disp_centi} !== {1'b1, 6'd1, 7'd0}) begin
      n_fail++; $display("FAIL count_100 got run=%b %0d.%0d exp run=1 1.00", running, disp_sec, disp_centi);
    end
  endtask

  task automatic test_pause();
    int w;
    do_reset();
    step(1, 0, 0);
    for (int i = 0; i < 2000 && m_live != 250; i++) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    n_tests++;
    if ({running, disp_sec, disp_centi} !== {1'b0, 6'd2, 7'd50}) begin
      n_fail++; $display("FAIL pause_hold got run=%b %0d.%0d exp run=0 2.50", running, disp_sec, disp_centi);
    end
    w = $urandom_range(200, 50);
    for (int i = 0; i < w; i++) begin
      step(0, 0, 1'($urandom_range(1)));
      n_tests++;
      if (dut_disp !== exp_disp()) begin
        n_fail++; $display("FAIL pause_disp got=%h exp=%h", dut_disp, exp_disp());
      end
    end
    step(1, 0, 0);
    for (int i = 0; i < 60; i++) begin
      step(0, 0, 0);
      n_tests++;
      if ({dut_disp, dut_flags} !== {exp_disp(), exp_flags()}) begin
        n_fail++; $display("FAIL resume got=%h/%b exp=%h/%b", dut_disp, dut_flags, exp_disp(), exp_flags());
      end
    end
    step(1, 0, 0);
    step(0, 1, 0);
    n_tests++;
    if ({dut_disp, dut_flags} !== '0) begin
      n_fail++; $display("FAIL pause_clear got=%h/%b exp=0/0", dut_disp, dut_flags);
    end
  endtask

  task automatic test_split();
    do_reset();
    step(1, 0, 0);
    for (int i = 0; i < 1000 && m_live != 30; i++) step(0, 0, 0);
    step(0, 1, 0);
    n_tests++;
    if ({frozen, disp_sec, disp_centi} !== {1'b1, 6'd0, 7'd30}) begin
      n_fail++; $display("FAIL split_lap0 got frz=%b %0d.%0d exp frz=1 0.30", frozen, disp_sec, disp_centi);
    end
    for (int i = 0; i < 1000 && m_live != 75; i++) begin
      step(0, 0, 0);
      n_tests++;
      if ({dut_disp, dut_flags} !== {exp_disp(), exp_flags()}) begin
        n_fail++; $display("FAIL split_hold got=%h/%b exp=%h/%b", dut_disp, dut_flags, exp_disp(), exp_flags());
      end
    end
    step(0, 1, 0);
    n_tests++;
`ifdef STOP_WATCH_LAP_DELTA_EN
    if ({lap_cnt, disp_sec, disp_centi} !== {LW'(2), 6'd0, 7'd45}) begin
      n_fail++; $display("FAIL split_lap1 got cnt=%0d %0d.%0d exp cnt=2 0.45", lap_cnt, disp_sec, disp_centi);
    end
`else
    if ({lap_cnt, disp_sec, disp_centi} !== {LW'(2), 6'd0, 7'd75}) begin
      n_fail++; $display("FAIL split_lap1 got cnt=%0d %0d.%0d exp cnt=2 0.75", lap_cnt, disp_sec, disp_centi);
    end
`endif
    for (int i = 0; i < 15; i++) step(0, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0);
      n_tests++;
      if ({dut_disp, dut_flags} !== {exp_disp(), exp_flags()}) begin
        n_fail++; $display("FAIL split_exit got=%h/%b exp=%h/%b", dut_disp, dut_flags, exp_disp(), exp_flags());
      end
    end
  endtask

  task automatic test_lap_full();
    int exp_idx [5] = '{0, 1, 2, 3, 0};
    do_reset();
    step(1, 0, 0);
    for (int c = 0; c < 5; c++) begin
      for (int i = $urandom_range(40, 5); i > 0; i--) step(0, 0, 0);
      step(0, 1, 0);
      n_tests++;
      if ({dut_disp, dut_flags} !== {exp_disp(), exp_flags()}) begin
        n_fail++; $display("FAIL lap_capture c=%0d got=%h/%b exp=%h/%b", c, dut_disp, dut_flags, exp_disp(), exp_flags());
      end
    end
    n_tests++;
    if ({lap_full, lap_cnt} !== {1'b1, LW'(LAP_DEPTH)}) begin
      n_fail++; $display("FAIL lap_full got full=%b cnt=%0d exp full=1 cnt=%0d", lap_full, lap_cnt, LAP_DEPTH);
    end
    step(1, 0, 0);
    step(1, 0, 0);
    for (int j = 0; j < 5; j++) begin
      step(0, 0, 1);
      step(0, 0, 0);
      n_tests++;
      if (lap_idx !== LW'(exp_idx[j]) || dut_disp !== exp_disp()) begin
        n_fail++; $display("FAIL recall_idx j=%0d got idx=%0d disp=%h exp idx=%0d disp=%h", j, lap_idx, dut_disp, exp_idx[j], exp_disp());
      end
    end
    step(0, 1, 0);
    step(0, 0, 0);
    n_tests++;
    if ({running, frozen} !== 2'b00 || dut_disp !== exp_disp()) begin
      n_fail++; $display("FAIL recall_exit got run=%b frz=%b disp=%h exp run=0 frz=0 disp=%h", running, frozen, dut_disp, exp_disp());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    step(1, 0, 0);
    for (int i = 0; i < 40000 && !m_ovf; i++) step(0, 0, 0);
    n_tests++;
    if ({ovf, dut_disp} !== {1'b1, cs_fields(WRAP - 1)}) begin
      n_fail++; $display("FAIL ovf_wrap got ovf=%b disp=%h exp ovf=1 disp=%h", ovf, dut_disp, cs_fields(WRAP - 1));
    end
    step(0, 0, 0);
    n_tests++;
    if ({ovf, dut_disp} !== {1'b1, {DW{1'b0}}}) begin
      n_fail++; $display("FAIL ovf_zero got ovf=%b disp=%h exp ovf=1 disp=0", ovf, dut_disp);
    end
    step(1, 0, 0);
    step(0, 1, 0);
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear got=%b exp=0", ovf);
    end
  endtask

  task automatic test_priority();
    do_reset();
    step(1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    step(0, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    step(1, 1, 0);
    n_tests++;
    if ({running, frozen, lap_cnt} !== {2'b00, LW'(1)}) begin
      n_fail++; $display("FAIL prio_k0k1 got run=%b frz=%b cnt=%0d exp run=0 frz=0 cnt=1", running, frozen, lap_cnt);
    end
    step(0, 0, 1);
    step(0, 0, 0);
    n_tests++;
    if ({dut_disp, dut_flags} !== {exp_disp(), exp_flags()}) begin
      n_fail++; $display("FAIL prio_recall got=%h/%b exp=%h/%b", dut_disp, dut_flags, exp_disp(), exp_flags());
    end
    rst = 1'b1;
    step(0, 1, 1);
    rst = 1'b0;
    n_tests++;
    if ({dut_disp, dut_flags} !== '0) begin
      n_fail++; $display("FAIL rst_recall got=%h/%b exp=0/0", dut_disp, dut_flags);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(23) == 0), 1'($urandom_range(11) == 0), 1'($urandom_range(7) == 0));
      n_tests++;
      if ({dut_disp, dut_flags} !== {exp_disp(), exp_flags()}) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h/%b exp=%h/%b", i, dut_disp, dut_flags, exp_disp(), exp_flags());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count();
    test_pause();
    test_split();
    test_lap_full();
    test_overflow();
    test_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
